// File: rtl/ctrl_stim_pkg.sv
// Shared opcode table, class/state enums and expected control-unit response for the stimulus sequencer.
// Pure definitions: no latency and no flow control.
package ctrl_stim_pkg;

  localparam logic [6:0] OPC_I  = 7'h13;
  localparam logic [6:0] OPC_R  = 7'h33;
  localparam logic [6:0] OPC_S  = 7'h23;
  localparam logic [6:0] OPC_SB = 7'h63;
  localparam logic [6:0] OPC_U  = 7'h37;
  localparam logic [6:0] OPC_UJ = 7'h6F;
  localparam int NUM_CLS = 6;

  typedef enum logic [2:0] {
    CLS_I  = 3'd0,
    CLS_R  = 3'd1,
    CLS_S  = 3'd2,
    CLS_SB = 3'd3,
    CLS_U  = 3'd4,
    CLS_UJ = 3'd5
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [5:0] en_vec;
    logic       rwr_en;
  } exp_t;

  function automatic logic [6:0] cls_opcode(cls_e c);
    case (c)
      CLS_R:   return OPC_R;
      CLS_S:   return OPC_S;
      CLS_SB:  return OPC_SB;
      CLS_U:   return OPC_U;
      CLS_UJ:  return OPC_UJ;
      default: return OPC_I;
    endcase
  endfunction

  function automatic exp_t cls_expect(cls_e c);
    exp_t e;
    e.en_vec = 6'b000001 << c;
    e.rwr_en = !(c == CLS_S || c == CLS_SB);
    return e;
  endfunction

  // Shift-immediate (I f3=5) and add/sub, shift-right (R f3=0/5) get a second func7 variant
  function automatic logic has_alt(cls_e c, logic [2:0] f3);
    return ((c == CLS_I) && (f3 == 3'd5)) ||
           ((c == CLS_R) && ((f3 == 3'd0) || (f3 == 3'd5)));
  endfunction

endpackage

// File: rtl/ctrl_stim_gen.sv
// Combinational vector walker: from the current class/func3/alt state, gives the next vector and whether this is the last.
// Zero latency; no flow control (the caller decides when to advance).
module ctrl_stim_gen
  import ctrl_stim_pkg::*;
#(
  parameter logic [5:0] OPC_MASK = 6'b111111
) (
  input  logic [2:0] cls_i,
  input  logic [2:0] func3_i,
  input  logic       alt_i,
  output logic       any_o,
  output logic [2:0] first_cls_o,
  output logic [2:0] nxt_cls_o,
  output logic [2:0] nxt_func3_o,
  output logic       nxt_alt_o,
  output logic       last_o
);

  logic [2:0] later_cls;
  logic       later_vld;

  assign any_o = |OPC_MASK;

  always_comb begin
    first_cls_o = 3'd0;
    later_cls   = 3'd0;
    later_vld   = 1'b0;
    // Descending scan so the lowest matching class wins
    for (int i = NUM_CLS - 1; i >= 0; i--) begin
      if (OPC_MASK[i]) begin
        first_cls_o = 3'(i);
        if (i > int'(cls_i)) begin
          later_cls = 3'(i);
          later_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt_cls_o   = cls_i;
    nxt_func3_o = func3_i;
    nxt_alt_o   = 1'b0;
    last_o      = 1'b0;
    if (!alt_i && has_alt(cls_e'(cls_i), func3_i)) begin
      nxt_alt_o = 1'b1;
    end else if (func3_i != 3'd7) begin
      nxt_func3_o = func3_i + 3'd1;
    end else begin
      nxt_func3_o = 3'd0;
      nxt_cls_o   = later_cls;
      last_o      = !later_vld;
    end
  end

endmodule

// File: rtl/ctrl_stim_seq.sv
// Control-unit stimulus sequencer/checker; vector appears 1 cycle after start, each held HOLD_CYCLES+1 cycles, no backpressure.
// Checker, mismatch counter and err_o exist only when CTRL_STIM_CHECK_EN is defined; otherwise they read 0.
module ctrl_stim_seq
  import ctrl_stim_pkg::*;
#(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [5:0] OPC_MASK    = 6'b111111,
  parameter logic [6:0] F7_ALT      = 7'h20,
  parameter int         CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [6:0]       opcode_o,
  output logic [2:0]       func3_o,
  output logic [6:0]       func7_o,
  output logic             vec_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [5:0]       vec_idx_o,
  input  logic [5:0]       en_vec_i,
  input  logic             rwr_en_i,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic             err_o
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_e            state_q,  state_d;
  logic [HW-1:0]     hold_q,   hold_d;
  logic [2:0]        cls_q,    cls_d;
  logic [2:0]        func3_q,  func3_d;
  logic              alt_q,    alt_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [6:0]        func7_q,  func7_d;
  logic              vld_q,    vld_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic [5:0]        idx_q,    idx_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              err_q,    err_d;

  logic       gen_any, gen_nxt_alt, gen_last;
  logic [2:0] gen_first, gen_nxt_cls, gen_nxt_func3;
  logic       chk_fail;

  ctrl_stim_gen #(.OPC_MASK(OPC_MASK)) u_gen (
    .cls_i       (cls_q),
    .func3_i     (func3_q),
    .alt_i       (alt_q),
    .any_o       (gen_any),
    .first_cls_o (gen_first),
    .nxt_cls_o   (gen_nxt_cls),
    .nxt_func3_o (gen_nxt_func3),
    .nxt_alt_o   (gen_nxt_alt),
    .last_o      (gen_last)
  );

`ifdef CTRL_STIM_CHECK_EN
  exp_t exp_w;
  assign exp_w    = cls_expect(cls_e'(cls_q));
  assign chk_fail = (en_vec_i != exp_w.en_vec) || (rwr_en_i != exp_w.rwr_en);
`else
  logic unused_cu;
  assign unused_cu = ^{en_vec_i, rwr_en_i};
  assign chk_fail  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cls_d    = cls_q;
    func3_d  = func3_q;
    alt_d    = alt_q;
    opcode_d = opcode_q;
    func7_d  = func7_q;
    vld_d    = vld_q;
    busy_d   = busy_q;
    done_d   = done_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (abort_i) begin
      state_d = ST_IDLE;
      hold_d  = '0;
      vld_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            hold_d = '0;
            idx_d  = 6'd0;
            cnt_d  = '0;
            err_d  = 1'b0;
            done_d = 1'b0;
            if (gen_any) begin
              state_d  = ST_DRIVE;
              cls_d    = gen_first;
              func3_d  = 3'd0;
              alt_d    = 1'b0;
              opcode_d = cls_opcode(cls_e'(gen_first));
              func7_d  = 7'h00;
              vld_d    = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (hold_q == HOLD_LAST) state_d = ST_CHECK;
          else                     hold_d  = hold_q + HW'(1);
        end
        ST_CHECK: begin
          // One count per failed vector, sticking at all-ones
          if (chk_fail) begin
            err_d = 1'b1;
            if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
          end
          hold_d = '0;
          if (gen_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            vld_d   = 1'b0;
          end else begin
            state_d  = ST_DRIVE;
            cls_d    = gen_nxt_cls;
            func3_d  = gen_nxt_func3;
            alt_d    = gen_nxt_alt;
            opcode_d = cls_opcode(cls_e'(gen_nxt_cls));
            func7_d  = gen_nxt_alt ? F7_ALT : 7'h00;
            idx_d    = idx_q + 6'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      cls_q    <= CLS_I;
      func3_q  <= 3'd0;
      alt_q    <= 1'b0;
      opcode_q <= OPC_I;
      func7_q  <= 7'h00;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= 6'd0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cls_q    <= cls_d;
      func3_q  <= func3_d;
      alt_q    <= alt_d;
      opcode_q <= opcode_d;
      func7_q  <= func7_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign opcode_o       = opcode_q;
  assign func3_o        = func3_q;
  assign func7_o        = func7_q;
  assign vec_valid_o    = vld_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign vec_idx_o      = idx_q;
  assign mismatch_cnt_o = cnt_q;
  assign err_o          = err_q;

endmodule
